// File: rtl/mac_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the mac_array_pipe datapath: default element format,
// saturation limits, lane-count helper and the control FSM state encoding.
package mac_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned FRAC_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RES   = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    function automatic int unsigned lane_count(input int unsigned num_ch,
                                               input int unsigned ch_w,
                                               input int unsigned data_w);
        return (num_ch * ch_w) / data_w;
    endfunction

    // Most positive / most negative value of a w-bit two's complement element.
    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
`timescale 1ns/1ps
// Per-beat datapath: LANES signed multipliers feeding a combinational binary
// adder tree; the tree is padded to a power of two with zero leaves.
module mac_lane_tree
    import mac_pkg::*;
#(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
    input  logic [LANES*DATA_W-1:0] act_i,
    input  logic [LANES*DATA_W-1:0] wgt_i,
    output logic signed [SUM_W-1:0] sum_c_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned PAD    = 1 << $clog2(LANES);

    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [SUM_W-1:0]  node_c [1:2*PAD-1];

    for (genvar g = 0; g < LANES; g++) begin : g_mul
        logic signed [DATA_W-1:0] a_c;
        logic signed [DATA_W-1:0] w_c;
        assign a_c        = act_i[g*DATA_W +: DATA_W];
        assign w_c        = wgt_i[g*DATA_W +: DATA_W];
        assign prod_c[g]  = PROD_W'(a_c) * PROD_W'(w_c);
    end

    // Heap-indexed tree: leaves at PAD..2*PAD-1, root at index 1.
    always_comb begin
        for (int n = 1; n < int'(2 * PAD); n++) begin
            node_c[n] = '0;
        end
        for (int i = 0; i < int'(LANES); i++) begin
            node_c[int'(PAD) + i] = SUM_W'(prod_c[i]);
        end
        for (int n = int'(PAD) - 1; n >= 1; n--) begin
            node_c[n] = node_c[2*n] + node_c[2*n+1];
        end
    end

    assign sum_c_o = node_c[1];

endmodule

// File: rtl/mac_array_pipe.sv
`timescale 1ns/1ps
// Streaming multi-channel MAC: accumulates a signed fixed-point dot product over
// vec_len beats, adds bias, rounds toward -inf and saturates; valid/ready output.
// Build option MAC_ARRAY_RELU_EN clamps negative results to zero.
module mac_array_pipe
    import mac_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 64,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ACC_W  = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   start,
    input  logic [LEN_W-1:0]       vec_len,
    input  logic [DATA_W-1:0]      bias,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] act_data,
    input  logic [NUM_CH*CH_W-1:0] wgt_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      dot_product,
    output logic                   sat_flag,
    output logic                   busy
);

    localparam int unsigned LANES = lane_count(NUM_CH, CH_W, DATA_W);
    localparam int unsigned SUM_W = 2 * DATA_W + $clog2(LANES);
    localparam int unsigned RES_W = ACC_W + 1;

    localparam logic signed [RES_W-1:0] RES_MAX = RES_W'(sat_max(DATA_W));
    localparam logic signed [RES_W-1:0] RES_MIN = RES_W'(sat_min(DATA_W));

    state_e                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  bias_q, bias_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]         dot_q, dot_d;
    logic                      sat_q, sat_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;

    logic signed [SUM_W-1:0]   beat_sum_c;
    logic signed [RES_W-1:0]   res_c;
    logic [DATA_W-1:0]         res_sat_c;
    logic                      res_clip_c;

    mac_lane_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_lane_tree (
        .act_i   (act_data),
        .wgt_i   (wgt_data),
        .sum_c_o (beat_sum_c)
    );

    // Shift-then-add keeps the result floor-rounded; one spare bit catches bias overflow.
    always_comb begin
        res_c      = RES_W'(acc_q >>> FRAC_W) + RES_W'(bias_q);
        res_sat_c  = DATA_W'(res_c);
        res_clip_c = 1'b0;
        if (res_c > RES_MAX) begin
            res_sat_c  = DATA_W'(RES_MAX);
            res_clip_c = 1'b1;
        end else if (res_c < RES_MIN) begin
            res_sat_c  = DATA_W'(RES_MIN);
            res_clip_c = 1'b1;
        end
`ifdef MAC_ARRAY_RELU_EN
        if (res_sat_c[DATA_W-1]) begin
            res_sat_c = '0;
        end
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        acc_d   = acc_q;
        sum_d   = '0;
        dot_d   = dot_q;
        sat_d   = sat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = vec_len;
                    bias_d  = bias;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (vec_len == '0) ? ST_RES : ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d = acc_q + ACC_W'(sum_q);
                if (in_valid) begin
                    sum_d = beat_sum_c;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + ACC_W'(sum_q);
                state_d = ST_RES;
            end
            ST_RES: begin
                dot_d   = res_sat_c;
                sat_d   = res_clip_c;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including a pending output handshake.
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sum_d   = '0;
            sat_d   = 1'b0;
        end

        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            dot_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            dot_q       <= dot_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign dot_product = dot_q;
    assign sat_flag    = sat_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mac_array_pipe.sv
`timescale 1ns/1ps
// Bench for mac_array_pipe: directed vector table, random vectors against an
// arithmetic dot-product model, and hand-written control corner cases.
module tb_mac_array_pipe;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 64;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ACC_W  = 48;
    localparam int unsigned LANES  = 16;
    localparam int unsigned BUS_W  = NUM_CH * CH_W;

`ifdef MAC_ARRAY_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  vec_len = '0;
    logic [DATA_W-1:0] bias = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BUS_W-1:0]  act_data = '0;
    logic [BUS_W-1:0]  wgt_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] dot_product;
    logic              sat_flag;
    logic              busy;

    mac_array_pipe #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .LEN_W  (LEN_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .start       (start),
        .vec_len     (vec_len),
        .bias        (bias),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .act_data    (act_data),
        .wgt_data    (wgt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dot_product (dot_product),
        .sat_flag    (sat_flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        int          len;
        logic [15:0] b;
        logic [15:0] act;
        logic [15:0] wgt;
        int          nl;
        int          bmode;
        logic [15:0] exp_d;
        bit          exp_s;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [BUS_W-1:0] act_beats[$];
    logic [BUS_W-1:0] wgt_beats[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] fill(input logic [15:0] v, input int nl);
        logic [BUS_W-1:0] r = '0;
        for (int l = 0; l < nl; l++) r[l*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [15:0] relu(input logic [15:0] v);
        return (RELU && v[15]) ? 16'h0000 : v;
    endfunction

    // Dot product over all queued beats, then floor(acc/2^FRAC_W) + bias, clamped to 16 bits.
    task automatic model(input logic [15:0] b, output logic [15:0] d, output bit s);
        longint acc = 0;
        longint r;
        for (int k = 0; k < act_beats.size(); k++)
            for (int l = 0; l < int'(LANES); l++)
                acc += longint'($signed(act_beats[k][l*16 +: 16])) *
                       longint'($signed(wgt_beats[k][l*16 +: 16]));
        r = (acc >>> FRAC_W) + longint'($signed(b));
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        if (RELU && r < 0) r = 0;
        d = 16'(r);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after an edge.
    task automatic run_vec(input string name, input int len, input logic [15:0] b, input int bmode,
                           input logic [15:0] exp_d, input bit exp_s, input bit consume);
        int   n_acc = 0;
        int   cyc = 0;
        logic rdy;
        start   = 1'b1;
        vec_len = LEN_W'(len);
        bias    = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (len == 0) begin
            chk({name, " lat_e1"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk({name, " lat_e2"}, 64'(out_valid), 64'd1);
        end else begin
            while (n_acc < len && cyc < 200) begin
                case (bmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 2 == 0);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                act_data = act_beats[n_acc];
                wgt_data = wgt_beats[n_acc];
                rdy = in_ready;
                @(posedge clk); #1;
                if (in_valid && rdy) n_acc++;
                cyc++;
            end
            chk({name, " beats"}, 64'(n_acc), 64'(len));
            chk({name, " rdy_drop"}, 64'(in_ready), 64'd0);
            chk({name, " lat_e1"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({name, " lat_e2"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk({name, " lat_e3"}, 64'(out_valid), 64'd1);
        end
        chk({name, " dot"}, 64'(dot_product), 64'(exp_d));
        chk({name, " sat"}, 64'(sat_flag), 64'(exp_s));
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({name, " done_valid"}, 64'(out_valid), 64'd0);
            chk({name, " done_busy"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic load(input int len, input logic [15:0] a, input logic [15:0] w, input int nl);
        act_beats.delete();
        wgt_beats.delete();
        for (int k = 0; k < len; k++) begin
            act_beats.push_back(fill(a, nl));
            wgt_beats.push_back(fill(w, nl));
        end
    endtask

    vec_t             tbl[9];
    logic [15:0]      ed;
    bit               es;
    int               rlen;
    logic [15:0]      rb;
    logic [BUS_W-1:0] ra, rw;
    logic [31:0]      r32;

    initial begin
        #2;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst dot", 64'(dot_product), 64'd0);
        chk("rst sat", 64'(sat_flag), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = '{"single",   1, 16'h0000, 16'h0100, 16'h0200,  1, 0, 16'h0200, 1'b0};
        tbl[1] = '{"bubbles",  4, 16'h0080, 16'h0100, 16'h0010, 16, 1, 16'h0480, 1'b0};
        tbl[2] = '{"sat_pos",  2, 16'h0000, 16'h7FFF, 16'h7FFF, 16, 0, 16'h7FFF, 1'b1};
        tbl[3] = '{"sat_neg",  1, 16'h0000, 16'h8000, 16'h7FFF, 16, 0, relu(16'h8000), 1'b1};
        tbl[4] = '{"zero_len", 0, 16'h0123, 16'h0000, 16'h0000, 16, 0, 16'h0123, 1'b0};
        tbl[5] = '{"neg_half", 1, 16'h0000, 16'hFF80, 16'h0100,  1, 0, relu(16'hFF80), 1'b0};
        tbl[6] = '{"floor",    1, 16'h0000, 16'hFFFF, 16'h0001,  1, 0, relu(16'hFFFF), 1'b0};
        tbl[7] = '{"bias_max", 0, 16'h7FFF, 16'h0000, 16'h0000, 16, 0, 16'h7FFF, 1'b0};
        tbl[8] = '{"bias_ovf", 1, 16'h7FFF, 16'h0100, 16'h0100,  1, 0, 16'h7FFF, 1'b1};

        for (int i = 0; i < 9; i++) begin
            load(tbl[i].len, tbl[i].act, tbl[i].wgt, tbl[i].nl);
            run_vec(tbl[i].name, tbl[i].len, tbl[i].b, tbl[i].bmode, tbl[i].exp_d, tbl[i].exp_s, 1'b1);
        end

        for (int t = 0; t < 24; t++) begin
            rlen = int'($urandom_range(1, 6));
            rb   = 16'($urandom);
            act_beats.delete();
            wgt_beats.delete();
            for (int k = 0; k < rlen; k++) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    r32 = $urandom;
                    if (t % 2 == 0) begin
                        ra[l*16 +: 16] = {{8{r32[7]}}, r32[7:0]};
                        rw[l*16 +: 16] = {{8{r32[15]}}, r32[15:8]};
                    end else begin
                        ra[l*16 +: 16] = r32[15:0];
                        rw[l*16 +: 16] = r32[31:16];
                    end
                end
                act_beats.push_back(ra);
                wgt_beats.push_back(rw);
            end
            model(rb, ed, es);
            run_vec($sformatf("rnd%0d", t), rlen, rb, 2, ed, es, 1'b1);
        end

        // Output backpressure with a stray start pulse that must be ignored.
        load(1, 16'h0100, 16'h0200, 1);
        run_vec("bp", 1, 16'h0000, 0, 16'h0200, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start   = 1'b1;
                vec_len = LEN_W'(1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("bp valid c%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp dot c%0d", k), 64'(dot_product), 64'h0200);
            chk($sformatf("bp in_ready c%0d", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release valid", 64'(out_valid), 64'd0);
        chk("bp release busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("bp start ignored", 64'(busy), 64'd0);

        // Abort after two of four beats.
        load(4, 16'h0100, 16'h0010, 16);
        start   = 1'b1;
        vec_len = LEN_W'(4);
        bias    = 16'h0080;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        act_data = act_beats[0];
        wgt_data = wgt_beats[0];
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr      = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd0);
        chk("abort valid", 64'(out_valid), 64'd0);
        chk("abort sat", 64'(sat_flag), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort no_out c%0d", k), 64'(out_valid), 64'd0);
        end
        load(1, 16'h0100, 16'h0200, 1);
        run_vec("post_abort", 1, 16'h0000, 0, 16'h0200, 1'b0, 1'b1);

        // Asynchronous reset in the middle of accumulation.
        load(4, 16'h0100, 16'h0010, 16);
        start   = 1'b1;
        vec_len = LEN_W'(4);
        bias    = 16'h0000;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        act_data = act_beats[0];
        wgt_data = wgt_beats[0];
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        chk("arst in_ready", 64'(in_ready), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst valid", 64'(out_valid), 64'd0);
        chk("arst dot", 64'(dot_product), 64'd0);
        chk("arst sat", 64'(sat_flag), 64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        load(0, 16'h0000, 16'h0000, 16);
        run_vec("post_rst", 0, 16'h0123, 0, 16'h0123, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
